// File: rtl/dds_phase_controller_if.sv
// Waveform table load stream between a sample source and the DDS controller.
interface dds_phase_controller_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready
   );
endinterface

// File: rtl/dds_phase_controller.sv
// DDS waveform RAM sequencer: table load over a valid/ready stream and
// phase-accumulator playback addressing with hold and live retuning.
module dds_phase_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int TW_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            cmd,
   input  logic                  start,
   input  logic                  stop,
   input  logic [TW_WIDTH-1:0]   tuning_word,
   input  logic                  tw_update,
   dds_phase_controller_if.slave ld,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  load_done,
   output logic                  wrap,
   output logic                  busy,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_HOLD = 2'b11
   } state_t;

   state_t st, st_n;

   logic [ACC_WIDTH-1:0]  acc, acc_n;
   logic [TW_WIDTH-1:0]   tw_reg, tw_n;
   logic [ADDR_WIDTH-1:0] count, count_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  we_n, done_n, wrap_n;
   logic [ACC_WIDTH:0]    sum;
   logic                  xfer, last;

   assign sum   = {1'b0, acc} + (ACC_WIDTH+1)'(tw_reg);
   assign xfer  = (st == S_LOAD) && ld.load_valid && ld.load_ready;
   assign last  = (count == {ADDR_WIDTH{1'b1}});
   assign state = st;

   always_ff @(posedge clk) begin
      if (reset) st <= S_IDLE;
      else       st <= st_n;
   end

   always_comb begin
      st_n    = st;
      acc_n   = acc;
      tw_n    = tw_reg;
      count_n = count;
      addr_n  = ram_addr;
      data_n  = ram_data;
      we_n    = 1'b0;
      done_n  = 1'b0;
      wrap_n  = 1'b0;
      if (tw_update && (st == S_RUN || st == S_HOLD))
         tw_n = tuning_word;
      if (stop) begin
         st_n   = S_IDLE;
         acc_n  = '0;
         addr_n = '0;
      end else begin
         unique case (st)
            S_IDLE: begin
               acc_n  = '0;
               addr_n = '0;
               if (start && cmd == 2'b01) begin
                  st_n    = S_LOAD;
                  count_n = '0;
               end else if (start && cmd == 2'b10) begin
                  st_n = S_RUN;
                  tw_n = tuning_word;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  we_n    = 1'b1;
                  addr_n  = count;
                  data_n  = ld.load_data;
                  count_n = count + ADDR_WIDTH'(1);
                  if (last) begin
                     done_n = 1'b1;
                     st_n   = S_IDLE;
                  end
               end
            end
            S_RUN: begin
               if (start && cmd == 2'b11) begin
                  st_n = S_HOLD;
               end else if (start && cmd == 2'b00) begin
                  st_n   = S_IDLE;
                  acc_n  = '0;
                  addr_n = '0;
               end else begin
                  acc_n  = sum[ACC_WIDTH-1:0];
                  addr_n = sum[ACC_WIDTH-1 -: ADDR_WIDTH];
                  wrap_n = sum[ACC_WIDTH];
               end
            end
            S_HOLD: begin
               // Resume keeps the held phase so playback is continuous.
               if (start && cmd == 2'b10) begin
                  st_n = S_RUN;
               end else if (start && cmd == 2'b00) begin
                  st_n   = S_IDLE;
                  acc_n  = '0;
                  addr_n = '0;
               end
            end
            default: st_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc           <= '0;
         tw_reg        <= '0;
         count         <= '0;
         ram_addr      <= '0;
         ram_we        <= 1'b0;
         ram_data      <= '0;
         ld.load_ready <= 1'b0;
         load_done     <= 1'b0;
         wrap          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         acc           <= acc_n;
         tw_reg        <= tw_n;
         count         <= count_n;
         ram_addr      <= addr_n;
         ram_we        <= we_n;
         ram_data      <= data_n;
         ld.load_ready <= (st_n == S_LOAD);
         load_done     <= done_n;
         wrap          <= wrap_n;
         busy          <= (st_n != S_IDLE);
      end
   end

endmodule

// File: tb/tb_dds_phase_controller.sv
// Self-checking bench for dds_phase_controller: vector table for playback,
// write scoreboard for table loads, hand sequences for hold/abort/reset.
module tb_dds_phase_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  cmd;
   logic        start, stop, tw_update;
   logic [15:0] tuning_word;
   logic [7:0]  ram_addr, ram_data;
   logic        ram_we, load_done, wrap, busy;
   logic [1:0]  state;

   dds_phase_controller_if #(.DATA_WIDTH(8)) ld ();

   dds_phase_controller dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (cmd),
      .start       (start),
      .stop        (stop),
      .tuning_word (tuning_word),
      .tw_update   (tw_update),
      .ld          (ld),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_data    (ram_data),
      .load_done   (load_done),
      .wrap        (wrap),
      .busy        (busy),
      .state       (state)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int passed = 0;
   int total  = 0;
   int done_cnt = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      logic       last;
   } wr_t;
   wr_t sb[$];

   typedef struct {
      logic       st;
      logic [1:0] cmd;
      logic       sp;
      logic       twu;
      logic [15:0] tw;
      logic [1:0] es;
      logic [7:0] ea;
      logic       ew;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      start     = 1'b0;
      cmd       = 2'b00;
      stop      = 1'b0;
      tw_update = 1'b0;
      ld.load_valid = 1'b0;
   endtask

   task automatic check_zero(input string nm);
      check(nm, {state, ram_addr, ram_we, ram_data, ld.load_ready,
                 load_done, wrap, busy}, 32'h0);
   endtask

   task automatic add(input logic s, input logic [1:0] c, input logic sp,
                      input logic twu, input logic [15:0] tw,
                      input logic [1:0] es, input logic [7:0] ea,
                      input logic ew);
      vec_t v;
      v.st = s; v.cmd = c; v.sp = sp; v.twu = twu; v.tw = tw;
      v.es = es; v.ea = ea; v.ew = ew;
      tbl.push_back(v);
   endtask

   // One stream cycle; a handshake pushes the expected write for next edge.
   task automatic load_cycle(input logic valid, input logic [7:0] data,
                             input logic [7:0] exp_addr, output bit taken);
      wr_t w;
      ld.load_valid = valid;
      ld.load_data  = data;
      taken = valid && ld.load_ready;
      if (taken) begin
         w.a = exp_addr; w.d = data; w.last = (exp_addr == 8'hFF);
         sb.push_back(w);
      end
      step();
      if (load_done) done_cnt++;
      if (sb.size() > 0) begin
         w = sb.pop_front();
         check("load_write", {ram_we, ram_addr, ram_data, load_done},
               {1'b1, w.a, w.d, w.last});
      end else begin
         check("load_stall", {ram_we, load_done}, 2'b00);
      end
   endtask

   initial begin
      bit taken;
      int idx, c, first_wrap;
      logic [15:0] m_acc;
      logic        carry;

      reset = 1'b1;
      idle_in();
      tuning_word  = 16'h0;
      ld.load_data = 8'h0;
      step();
      step();
      reset = 1'b0;
      check_zero("reset_state");

      add(1, 2'b10, 0, 0, 16'h8000, 2'b10, 8'h00, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h80, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h00, 1);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h80, 0);
      add(0, 2'b00, 0, 1, 16'h4000, 2'b10, 8'h00, 1);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h40, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h80, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'hC0, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h00, 1);
      add(1, 2'b11, 0, 1, 16'h0200, 2'b11, 8'h00, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b11, 8'h00, 0);
      add(1, 2'b10, 0, 0, 16'h0000, 2'b10, 8'h00, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h02, 0);
      add(1, 2'b01, 0, 0, 16'h0000, 2'b10, 8'h04, 0);
      add(1, 2'b11, 1, 0, 16'h0000, 2'b00, 8'h00, 0);
      add(1, 2'b11, 0, 0, 16'h0000, 2'b00, 8'h00, 0);
      add(1, 2'b10, 0, 0, 16'h0000, 2'b10, 8'h00, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h00, 0);
      add(0, 2'b00, 0, 0, 16'h0000, 2'b10, 8'h00, 0);
      add(1, 2'b00, 0, 0, 16'h0000, 2'b00, 8'h00, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         start       = tbl[i].st;
         cmd         = tbl[i].cmd;
         stop        = tbl[i].sp;
         tw_update   = tbl[i].twu;
         tuning_word = tbl[i].tw;
         step();
         idle_in();
         check($sformatf("vec%0d", i),
               {state, ram_addr, wrap, ram_we, busy},
               {tbl[i].es, tbl[i].ea, tbl[i].ew, 1'b0, tbl[i].es != 2'b00});
      end

      start = 1'b1; cmd = 2'b10; tuning_word = 16'h0100;
      step();
      idle_in();
      check("run_start", {state, ram_addr}, {2'b10, 8'h00});
      m_acc = 16'h0;
      first_wrap = -1;
      for (int k = 1; k <= 300; k++) begin
         step();
         {carry, m_acc} = {1'b0, m_acc} + 17'h0100;
         if (wrap && first_wrap < 0) first_wrap = k;
         check("run_step", {ram_we, ram_addr, wrap},
               {1'b0, m_acc[15:8], carry});
      end
      check("first_wrap_cycle", first_wrap, 256);
      stop = 1'b1;
      step();
      idle_in();

      start = 1'b1; cmd = 2'b10; tuning_word = 16'h0100;
      step();
      idle_in();
      for (int k = 0; k < 4; k++) step();
      check("pre_hold_addr", ram_addr, 8'h04);
      start = 1'b1; cmd = 2'b11;
      step();
      idle_in();
      check("hold_enter", {state, ram_addr}, {2'b11, 8'h04});
      for (int k = 0; k < 20; k++) begin
         step();
         check("hold_frozen", {state, ram_addr, wrap}, {2'b11, 8'h04, 1'b0});
      end
      start = 1'b1; cmd = 2'b10;
      step();
      idle_in();
      check("resume", {state, ram_addr}, {2'b10, 8'h04});
      step();
      check("resume_05", ram_addr, 8'h05);
      step();
      check("resume_06", ram_addr, 8'h06);
      stop = 1'b1;
      step();
      idle_in();

      start = 1'b1; cmd = 2'b01;
      step();
      idle_in();
      check("load_enter", {state, ld.load_ready, busy}, {2'b01, 1'b1, 1'b1});
      idx = 0;
      c = 0;
      done_cnt = 0;
      while (idx < 256 && c < 1000) begin
         load_cycle((c % 3) != 2, idx[7:0], idx[7:0], taken);
         if (taken) idx++;
         c++;
      end
      ld.load_valid = 1'b0;
      check("load_count", idx, 256);
      check("load_exit", {state, ld.load_ready, busy}, 4'b0000);
      step();
      check("load_done_once", {done_cnt[7:0], load_done, ram_we},
            {8'd1, 1'b0, 1'b0});

      start = 1'b1; cmd = 2'b01;
      step();
      idle_in();
      done_cnt = 0;
      for (int i = 0; i < 10; i++)
         load_cycle(1'b1, 8'h10 + 8'(i), 8'(i), taken);
      ld.load_valid = 1'b0;
      stop = 1'b1;
      step();
      idle_in();
      check("abort", {state, ld.load_ready, ram_we, load_done, ram_addr},
            {2'b00, 1'b0, 1'b0, 1'b0, 8'h00});
      check("abort_no_done", done_cnt, 0);
      start = 1'b1; cmd = 2'b01;
      step();
      idle_in();
      load_cycle(1'b1, 8'hAA, 8'h00, taken);
      check("reload_taken", taken, 1);
      ld.load_valid = 1'b0;
      stop = 1'b1;
      step();
      idle_in();

      start = 1'b1; cmd = 2'b10; tuning_word = 16'h1234;
      step();
      idle_in();
      for (int k = 0; k < 5; k++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_zero("reset_mid_run");
      start = 1'b1; cmd = 2'b11;
      step();
      idle_in();
      check("idle_ignores_hold", {state, busy, ram_addr}, 11'h0);

      start = 1'b1; cmd = 2'b01;
      step();
      idle_in();
      load_cycle(1'b1, 8'h55, 8'h00, taken);
      reset = 1'b1;
      ld.load_valid = 1'b1;
      ld.load_data  = 8'h66;
      step();
      reset = 1'b0;
      ld.load_valid = 1'b0;
      check_zero("reset_mid_load");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dds_phase_controller.md
Name: dds_phase_controller

Overview:
Sequencer for the DDS waveform RAM (single-port, DATA_WIDTH x 2^ADDR_WIDTH). It has two jobs: loading a waveform table into the RAM through a valid/ready stream, and generating the playback address from a phase accumulator advanced by a programmable tuning word. It owns the RAM's address, write-enable and write-data pins; the RAM read port q is the DDS output. It replaces the fixed-step address state machine with a command-driven controller supporting load, run, hold and live frequency updates.

Parameters:
DATA_WIDTH, 8, waveform sample width
ADDR_WIDTH, 8, RAM address width (table depth 2^ADDR_WIDTH)
ACC_WIDTH, 16, phase accumulator width; must be >= ADDR_WIDTH
TW_WIDTH, 16, tuning word width; must be <= ACC_WIDTH, zero-extended into the accumulator

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; highest priority
cmd  input  2  command, 00 IDLE, 01 LOAD, 10 RUN, 11 HOLD; sampled only when start=1
start  input  1  single-cycle command strobe
stop  input  1  abort to IDLE; priority over start
tuning_word  input  TW_WIDTH  phase increment
tw_update  input  1  load tuning_word into the increment register while in RUN or HOLD
load_valid  input  1  load_data is valid
load_data  input  DATA_WIDTH  table sample
load_ready  output  1  controller accepts a sample
ram_addr  output  ADDR_WIDTH  RAM address
ram_we  output  1  RAM write enable
ram_data  output  DATA_WIDTH  RAM write data
load_done  output  1  one-cycle pulse, table fully written
wrap  output  1  one-cycle pulse on accumulator carry-out
busy  output  1  state != IDLE
state  output  2  00 IDLE, 01 LOAD, 10 RUN, 11 HOLD

Behaviour:
- Reset (sync): the following all go to 0 on the next edge: state IDLE, acc, tw_reg, load count, ram_addr, ram_we, ram_data, load_ready, load_done, wrap, busy.
- All outputs are registered. Every transition below takes effect on the edge after the triggering inputs.
- IDLE:
  - ram_addr=0, ram_we=0, acc=0.
  - start&cmd=01 -> LOAD, count=0.
  - start&cmd=10 -> RUN, acc=0, tw_reg=tuning_word.
  - start with cmd 00 or 11 is ignored.
- LOAD:
  - load_ready=1 while in LOAD. It is 0 in all other states, including the first cycle of the IDLE->LOAD transition.
  - Transfer occurs when load_valid&load_ready.
  - Next cycle after a transfer: ram_we=1, ram_addr=count, ram_data=load_data, count+1.
  - No transfer: ram_we=0, ram_addr and ram_data hold.
  - Transfer of word 2^ADDR_WIDTH-1: the next cycle carries that write plus load_done=1, state=IDLE, load_ready=0.
  - start is ignored in LOAD.
- RUN:
  - Every cycle acc <= acc + tw_reg (mod 2^ACC_WIDTH).
  - ram_addr <= upper ADDR_WIDTH bits of the new acc; ram_we=0.
  - wrap=1 in the cycle the registered acc resulted from a carry-out.
  - tw_update=1: tw_reg <= tuning_word; it is used from the following accumulation onward.
  - start&cmd=11 -> HOLD. start&cmd=00 -> IDLE.
- HOLD:
  - acc, ram_addr and tw_reg are frozen, except that tw_update still loads tw_reg.
  - wrap=0.
  - start&cmd=10 -> RUN, resuming from the held acc (acc is not cleared).
  - start&cmd=00 -> IDLE.
- stop=1 in any state: IDLE on the next edge.
  - ram_we=0, load_ready=0, acc=0, ram_addr=0.
  - An aborted load keeps its partially written words and does not pulse load_done.
- Boundaries:
  - tw_reg=0 in RUN: ram_addr static, wrap never asserts.
  - tw_update coincident with a start to HOLD: both take effect.
  - stop and start in the same cycle: stop wins.
  - Reset mid-LOAD or mid-RUN: behaves exactly as the reset bullet above.

Test Plan:
- Reset, start cmd=10 tw=0x0100 at T -> T+1 state=10, ram_addr=0x00; ram_addr increments by 1 per cycle; wrap pulses when acc rolls 0xFF00->0x0000 (256 cycles after T+1); ram_we stays 0.
- RUN tw=0x8000 -> ram_addr alternates 0x00, 0x80, 0x00 ... with wrap on every 0x00 after the first. Mid-run tw_update tw=0x4000 -> step becomes 0x40 on the following accumulation.
- LOAD 256 samples, data=index, with load_valid deasserted every 3rd cycle -> ram_we/ram_addr/ram_data write 0x00..0xFF in order, no writes on stall cycles. load_done pulses once together with the addr 0xFF write; state returns to 00 and load_ready=0.
- LOAD, stop after 10 transfers -> next cycle state=00, load_ready=0, ram_we=0, no load_done. A new LOAD restarts at address 0.
- RUN tw=0x0100 for 5 cycles (ram_addr=0x04), start cmd=11 -> ram_addr holds 0x04 for 20 cycles; start cmd=10 -> continues 0x05, 0x06.
- reset asserted mid-RUN and held 1 cycle -> all outputs 0 on the next edge, state=00. start with cmd=11 from IDLE -> ignored.
